// File: rtl/ps2_matrix_keyboard_if.sv
// Bus bundle for the PS/2-to-matrix keyboard: event input, map-table write
// port, control pulse and matrix read-back.
interface ps2_matrix_keyboard_if #(
  parameter int KEY_AW = 6
);
  logic [10:0]       ps2_key;
  logic              map_we;
  logic [8:0]        map_addr;
  logic [KEY_AW:0]   map_data;
  logic              clear_all;
  logic [KEY_AW-1:0] addr;
  logic              key_out;
  logic              any_key;
  logic              overflow;

  modport master (
    output ps2_key, map_we, map_addr, map_data, clear_all, addr,
    input  key_out, any_key, overflow
  );

  modport slave (
    input  ps2_key, map_we, map_addr, map_data, clear_all, addr,
    output key_out, any_key, overflow
  );
endinterface

// File: rtl/ps2_matrix_keyboard.sv
// Converts toggled PS/2 key events into a key matrix through a programmable
// map table, with an event FIFO and a minimum visible press duration.
module ps2_matrix_keyboard #(
  parameter int KEY_AW      = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16
) (
  input logic clk,
  input logic reset,
  ps2_matrix_keyboard_if.slave bus
);
  localparam int NUM_KEYS = 2 ** KEY_AW;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int PTRW     = PW + 1;
  localparam int TW       = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, APPLY, WAIT_HOLD} state_t;

  state_t            state, next_state;
  logic              toggle_q;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [9:0]        fifo_mem [FIFO_DEPTH];
  logic [KEY_AW:0]   map_mem [512];
  logic [NUM_KEYS-1:0] keys;
  logic [TW-1:0]     hold_timer;
  logic [KEY_AW-1:0] hold_idx;
  logic              ev_pressed;
  logic [KEY_AW:0]   entry_q;
  logic              key_out_q, any_key_q, overflow_q;

  logic              event_det, fifo_empty, fifo_full, timer_last;
  logic              lookup, pop, push_ok, drop;
  logic              set_key, clr_key, load_timer;
  logic [9:0]        fifo_head;
  logic [KEY_AW-1:0] entry_idx, clr_idx;

  assign entry_idx  = entry_q[KEY_AW-1:0];
  assign timer_last = hold_timer <= TW'(1);
  assign event_det  = bus.ps2_key[10] ^ toggle_q;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign fifo_head  = fifo_mem[rd_ptr[PW-1:0]];
  // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
  assign pop        = lookup && !bus.clear_all;
  assign push_ok    = event_det && (!fifo_full || pop);
  assign drop       = event_det && fifo_full && !pop;

  assign bus.key_out  = key_out_q;
  assign bus.any_key  = any_key_q;
  assign bus.overflow = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (!fifo_empty) next_state = APPLY;
      APPLY: begin
        if (entry_q[KEY_AW] && !ev_pressed && entry_idx == hold_idx && hold_timer != '0)
          next_state = WAIT_HOLD;
        else
          next_state = IDLE;
      end
      WAIT_HOLD: if (timer_last) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    if (bus.clear_all) next_state = IDLE;
  end

  always_comb begin
    lookup     = 1'b0;
    set_key    = 1'b0;
    clr_key    = 1'b0;
    load_timer = 1'b0;
    clr_idx    = entry_idx;
    case (state)
      IDLE: lookup = !fifo_empty;
      APPLY: begin
        if (entry_q[KEY_AW]) begin
          if (ev_pressed) begin
            set_key    = 1'b1;
            load_timer = 1'b1;
          end else if (entry_idx != hold_idx || hold_timer == '0) begin
            clr_key = 1'b1;
          end
        end
      end
      WAIT_HOLD: begin
        if (timer_last) begin
          clr_key = 1'b1;
          clr_idx = hold_idx;
        end
      end
      default: ;
    endcase
  end

  // The toggle history follows ps2_key even in reset so release creates no event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle_q   <= bus.ps2_key[10];
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      keys       <= '0;
      hold_timer <= '0;
      hold_idx   <= '0;
      overflow_q <= 1'b0;
      key_out_q  <= 1'b0;
      any_key_q  <= 1'b0;
    end else begin
      toggle_q  <= bus.ps2_key[10];
      key_out_q <= keys[bus.addr];
      any_key_q <= |keys;
      if (bus.clear_all) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        keys       <= '0;
        hold_timer <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (pop)     rd_ptr <= rd_ptr + PTRW'(1);
        if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
        if (drop)    overflow_q <= 1'b1;
        if (set_key) begin
          keys[entry_idx] <= 1'b1;
          hold_idx        <= entry_idx;
        end
        if (clr_key) keys[clr_idx] <= 1'b0;
        if (load_timer)            hold_timer <= TW'(HOLD_CYCLES);
        else if (hold_timer != '0) hold_timer <= hold_timer - TW'(1);
      end
    end
  end

  // Storage arrays are not reset; a same-cycle map write is seen by the next lookup only.
  always_ff @(posedge clk) begin
    if (push_ok)    fifo_mem[wr_ptr[PW-1:0]] <= bus.ps2_key[9:0];
    if (bus.map_we) map_mem[bus.map_addr]    <= bus.map_data;
    if (pop) begin
      ev_pressed <= fifo_head[9];
      entry_q    <= map_mem[fifo_head[8:0]];
    end
  end
endmodule

// File: doc/ps2_matrix_keyboard.md
PS2_MATRIX_KEYBOARD -- requirements
Module: ps2_matrix_keyboard

Interface
REQ-001 SHALL have parameter KEY_AW, default 6, giving the key-matrix index width; the matrix holds 2**KEY_AW key bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, a power of two >= 2, giving the number of queued PS/2 events.
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, a value >= 1, giving the minimum visible press duration in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-006 SHALL have port ps2_key, input, 11 bits: [10] event toggle, [9] pressed, [8] extended flag, [7:0] scan code.
REQ-007 SHALL have port map_we, input, 1 bit, a map-table write strobe.
REQ-008 SHALL have port map_addr, input, 9 bits, the map-table address {extended, code}.
REQ-009 SHALL have port map_data, input, KEY_AW+1 bits: [KEY_AW] entry valid, [KEY_AW-1:0] matrix index.
REQ-010 SHALL have port clear_all, input, 1 bit, a synchronous pulse that releases all keys and flushes the queue.
REQ-011 SHALL have port addr, input, KEY_AW bits, the matrix read index.
REQ-012 SHALL have port key_out, output, 1 bit, the registered state of the key at addr.
REQ-013 SHALL have port any_key, output, 1 bit, registered; high when any matrix bit is set.
REQ-014 SHALL have port overflow, output, 1 bit, a sticky flag set when an event is dropped because the queue is full.

Function
REQ-015 SHALL detect an event when ps2_key[10] differs from its value registered on the previous cycle; one event per change.
REQ-016 SHALL push {pressed, extended, code} of each detected event into the FIFO in the same cycle.
REQ-017 SHALL drop an event that arrives while the FIFO is full, leave the FIFO unchanged, and set overflow; overflow clears only on reset or clear_all.
REQ-018 SHALL accept a push and a pop in the same cycle when the FIFO is full; the push is not dropped.
REQ-019 SHALL hold a 512-entry map table written on map_we (map_addr <= map_data), one entry per cycle; contents are not reset.
REQ-020 SHALL implement the controller FSM with states IDLE, APPLY and WAIT_HOLD.
REQ-021 In IDLE with the FIFO non-empty, the FSM SHALL pop the head event, look up map[{ext,code}], and go to APPLY.
REQ-022 In APPLY with an invalid map entry, the FSM SHALL discard the event and return to IDLE.
REQ-023 In APPLY, a press SHALL set keys[idx], load hold_timer with HOLD_CYCLES, record hold_idx = idx, and return to IDLE.
REQ-024 In APPLY, a release with idx != hold_idx or hold_timer == 0 SHALL clear keys[idx] and return to IDLE.
REQ-025 In APPLY, a release with idx == hold_idx and hold_timer != 0 SHALL go to WAIT_HOLD.
REQ-026 In WAIT_HOLD, the FSM SHALL clear keys[hold_idx] in the cycle hold_timer reaches 0, then return to IDLE; FIFO events stay queued meanwhile.
REQ-027 hold_timer SHALL decrement by 1 each cycle while non-zero, in every state, and saturate at 0.
REQ-028 A repeated press of an already-set key SHALL set the key again (no change) and reload the timer.
REQ-029 Best-case latency from the ps2_key[10] toggle to the keys bit changing SHALL be 3 cycles; key_out SHALL follow one cycle later.
REQ-030 key_out SHALL be keys[addr] registered every cycle; any_key SHALL be the registered OR-reduction of keys.
REQ-031 clear_all SHALL, in the cycle it is high: clear all keys, flush the FIFO, zero hold_timer, force IDLE, clear overflow, and discard any event detected in that cycle.
REQ-032 A map_we write in the same cycle as a lookup of the same address SHALL return the old entry.

Reset
REQ-033 While reset is low, the block SHALL asynchronously clear keys, the FIFO pointers, hold_timer, hold_idx and overflow, and force state to IDLE.
REQ-034 While reset is low, the block SHALL force key_out and any_key to 0 and load the toggle history register from the current ps2_key[10], so that no event is generated at reset release.

Verification
REQ-035 Map {0,0x1C} to 1; toggle with press 0x1C; 3 cycles later keys[1]=1; with addr=1, key_out=1 on the next cycle; any_key=1.
REQ-036 Press 0x1C, then release it 2 cycles later (HOLD_CYCLES=16) -> key_out stays 1 until 16 cycles after the press is applied, then returns to 0.
REQ-037 Generate 6 toggles on consecutive cycles while the FSM is held in WAIT_HOLD (FIFO_DEPTH=4) -> 4 events are applied in order, 2 are dropped, overflow=1.
REQ-038 Map {1,0x75} to 27 and {0,0x75} to 40 -> an extended 0x75 press sets only bit 27, a plain 0x75 press sets only bit 40; an unmapped code changes nothing.
REQ-039 Assert clear_all while 3 keys are held, 2 events are queued and an event is detected in the same cycle -> all keys are 0, the FIFO is empty, overflow=0, and the 2 queued events plus the same-cycle event are never applied.
REQ-040 Drive reset low mid-WAIT_HOLD -> key_out=0 and any_key=0 immediately; after release, no spurious event occurs with ps2_key[10] unchanged.
